// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : Decode/ALU pipeline register with EX/MEM + MEM/WB operand
//            forwarding, load-use bubble insertion and branch flush.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [RA_W-1:0] in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [3:0]      in_alu_ctrl,
    input  logic            in_add_sub_sel,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,

    input  logic            flush,

    input  logic            mem_fwd_we,
    input  logic [RA_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_we,
    input  logic [RA_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [XLEN-1:0] out_store_data,
    output logic [3:0]      out_alu_ctrl,
    output logic            out_add_sub_sel,
    output logic [RA_W-1:0] out_rd_addr,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [XLEN-1:0] out_pc,
    output logic            load_use_stall
);

    localparam logic [RA_W-1:0] c_zero_reg = '0;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [RA_W-1:0] r_rs1_addr;
    logic [RA_W-1:0] r_rs2_addr;
    logic [RA_W-1:0] r_rd_addr;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic            r_use_imm;
    logic [3:0]      r_alu_ctrl;
    logic            r_add_sub_sel;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;

    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic [XLEN-1:0] w_rs1_capture;
    logic [XLEN-1:0] w_rs2_capture;
    logic            w_load_use;
    logic            w_accept;
    logic            w_hold;

    // x0 reads as zero; the younger EX/MEM result wins over MEM/WB.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] base,
        input logic            m_we,
        input logic [RA_W-1:0] m_rd,
        input logic [XLEN-1:0] m_data,
        input logic            w_we,
        input logic [RA_W-1:0] w_rd,
        input logic [XLEN-1:0] w_data
    );
        logic [XLEN-1:0] res;
        if (addr == c_zero_reg)
            res = '0;
        else if (m_we && (m_rd == addr))
            res = m_data;
        else if (w_we && (w_rd == addr))
            res = w_data;
        else
            res = base;
        return res;
    endfunction

    // At capture only MEM/WB can be bypassed: it covers a regfile write
    // landing in the same cycle as the regfile read.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] base,
        input logic            w_we,
        input logic [RA_W-1:0] w_rd,
        input logic [XLEN-1:0] w_data
    );
        logic [XLEN-1:0] res;
        if ((addr != c_zero_reg) && w_we && (w_rd == addr))
            res = w_data;
        else
            res = base;
        return res;
    endfunction

    always_comb begin
        w_rs1_fwd = fwd_sel(r_rs1_addr, r_rs1_data, mem_fwd_we, mem_fwd_rd,
                            mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data);
        w_rs2_fwd = fwd_sel(r_rs2_addr, r_rs2_data, mem_fwd_we, mem_fwd_rd,
                            mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data);
        w_rs1_capture = wb_bypass(in_rs1_addr, in_rs1_data, wb_fwd_we,
                                  wb_fwd_rd, wb_fwd_data);
        w_rs2_capture = wb_bypass(in_rs2_addr, in_rs2_data, wb_fwd_we,
                                  wb_fwd_rd, wb_fwd_data);
    end

    // Both sources are compared even for immediate forms (conservative).
    assign w_load_use = r_valid && r_mem_read && (r_rd_addr != c_zero_reg) &&
                        in_valid &&
                        ((in_rs1_addr == r_rd_addr) || (in_rs2_addr == r_rd_addr));

    assign in_ready = rst_n && (!r_valid || out_ready) && !w_load_use;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_hold   = r_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_valid <= 1'b0;
        else if (flush)
            r_valid <= 1'b0;
        else if (w_accept)
            r_valid <= 1'b1;
        else if (r_valid && out_ready)
            r_valid <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_rs1_addr    <= '0;
            r_rs2_addr    <= '0;
            r_rd_addr     <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_use_imm     <= 1'b0;
            r_alu_ctrl    <= '0;
            r_add_sub_sel <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else if (w_accept) begin
            r_pc          <= in_pc;
            r_rs1_addr    <= in_rs1_addr;
            r_rs2_addr    <= in_rs2_addr;
            r_rd_addr     <= in_rd_addr;
            r_rs1_data    <= w_rs1_capture;
            r_rs2_data    <= w_rs2_capture;
            r_imm         <= in_imm;
            r_use_imm     <= in_use_imm;
            r_alu_ctrl    <= in_alu_ctrl;
            r_add_sub_sel <= in_add_sub_sel;
            r_reg_write   <= in_reg_write;
            r_mem_read    <= in_mem_read;
            r_mem_write   <= in_mem_write;
        end else if (w_hold) begin
            // Re-latch forwarded operands so they outlive the producer.
            r_rs1_data <= w_rs1_fwd;
            r_rs2_data <= w_rs2_fwd;
        end
    end

    assign out_valid       = r_valid;
    assign alu_src1        = w_rs1_fwd;
    assign alu_src2        = r_use_imm ? r_imm : w_rs2_fwd;
    assign out_store_data  = w_rs2_fwd;
    assign out_alu_ctrl    = r_alu_ctrl;
    assign out_add_sub_sel = r_add_sub_sel;
    assign out_rd_addr     = r_rd_addr;
    assign out_reg_write   = r_reg_write && r_valid;
    assign out_mem_read    = r_mem_read && r_valid;
    assign out_mem_write   = r_mem_write && r_valid;
    assign out_pc          = r_pc;
    assign load_use_stall  = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Self-checking bench for id_ex_stage: operand table, directed
//            hazard/flush/reset sequences and a randomized reference model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm;
    logic [3:0]  in_alu_ctrl;
    logic        in_add_sub_sel, in_reg_write, in_mem_read, in_mem_write;
    logic        flush;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_src1, alu_src2, out_store_data, out_pc;
    logic [3:0]  out_alu_ctrl;
    logic        out_add_sub_sel;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write, out_mem_read, out_mem_write, load_use_stall;

    int n_checks = 0;
    int n_err    = 0;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl), .in_add_sub_sel(in_add_sub_sel),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .flush(flush),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .out_store_data(out_store_data),
        .out_alu_ctrl(out_alu_ctrl), .out_add_sub_sel(out_add_sub_sel),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_pc(out_pc), .load_use_stall(load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic ui, input logic [3:0] ctrl,
                          input logic rw, input logic mr, input logic mw);
        in_valid = v; in_pc = pc;
        in_rs1_addr = r1; in_rs2_addr = r2; in_rd_addr = rd;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
        in_use_imm = ui; in_alu_ctrl = ctrl; in_add_sub_sel = ctrl[3];
        in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mdat,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wdat);
        mem_fwd_we = mwe; mem_fwd_rd = mrd; mem_fwd_data = mdat;
        wb_fwd_we = wwe; wb_fwd_rd = wrd; wb_fwd_data = wdat;
    endtask

    // Operand-table record: instruction captured with forwarding idle, then
    // the listed forwarding applied while it is held.
    typedef struct packed {
        logic [4:0]  rs1, rs2;
        logic [31:0] d1, d2, imm;
        logic        ui;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] e1, e2, es;
    } vec_t;

    vec_t vecs [8];

    // Reference model: one architectural "held instruction" slot.
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  r1, r2, rd;
        logic [31:0] d1, d2, imm;
        logic        ui;
        logic [3:0]  ctrl;
        logic        asel, rw, mr, mw;
    } held_t;

    function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] base);
        if (a == 5'd0) return 32'd0;
        if (mem_fwd_we && mem_fwd_rd == a) return mem_fwd_data;
        if (wb_fwd_we && wb_fwd_rd == a) return wb_fwd_data;
        return base;
    endfunction

    initial begin
        held_t m, mn;
        logic  e_stall, e_rdy, e_acc;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_in(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h5678);
        #12;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk("reset_alu_src1", alu_src1, 32'h0);
        chk("reset_alu_src2", alu_src2, 32'h0);
        chk("reset_pc", out_pc, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk1("reset_in_ready", in_ready, 1'b1);
        tick();

        vecs[0] = '{5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h11, 32'h22, 32'h22};
        vecs[1] = '{5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 1'b0, 1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 32'h10, 32'h44, 32'h44};
        vecs[2] = '{5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 1'b0, 1'b0, 5'd4, 32'h66, 1'b1, 5'd4, 32'h55, 32'h33, 32'h55, 32'h55};
        vecs[3] = '{5'd6, 5'd6, 32'h60, 32'h61, 32'h0, 1'b0, 1'b1, 5'd6, 32'hA, 1'b1, 5'd6, 32'hB, 32'hA, 32'hA, 32'hA};
        vecs[4] = '{5'd0, 5'd5, 32'h123, 32'h5, 32'hFFFFFFFC, 1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd5, 32'h77, 32'h0, 32'hFFFFFFFC, 32'h77};
        vecs[5] = '{5'd7, 5'd0, 32'h70, 32'h99, 32'h0, 1'b0, 1'b0, 5'd7, 32'hDEAD, 1'b1, 5'd7, 32'hBEEF, 32'hBEEF, 32'h0, 32'h0};
        vecs[6] = '{5'd8, 5'd9, 32'h88, 32'h90, 32'h100, 1'b1, 1'b1, 5'd9, 32'h9999, 1'b0, 5'd9, 32'h1, 32'h88, 32'h100, 32'h9999};
        vecs[7] = '{5'd31, 5'd30, 32'hF1, 32'hF0, 32'h0, 1'b0, 1'b0, 5'd31, 32'h3, 1'b0, 5'd30, 32'h4, 32'hF1, 32'hF0, 32'hF0};

        for (int i = 0; i < 8; i++) begin
            set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            set_in(1'b1, 32'h1000 + 32'(i * 4), vecs[i].rs1, vecs[i].rs2, 5'd12,
                   vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].ui, 4'h0, 1'b1, 1'b0, 1'b0);
            out_ready = 1'b1;
            #1;
            chk1("tbl_in_ready", in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
            set_fwd(vecs[i].mwe, vecs[i].mrd, vecs[i].mdat, vecs[i].wwe, vecs[i].wrd, vecs[i].wdat);
            #1;
            chk1("tbl_out_valid", out_valid, 1'b1);
            chk("tbl_pc", out_pc, 32'h1000 + 32'(i * 4));
            chk("tbl_alu_src1", alu_src1, vecs[i].e1);
            chk("tbl_alu_src2", alu_src2, vecs[i].e2);
            chk("tbl_store_data", out_store_data, vecs[i].es);
            tick();
        end
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Back-to-back ADD x3=x1+x2 then SUB x4=x3-x1.
        set_in(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h204, 5'd3, 5'd1, 5'd4, 32'h0, 32'h1, 32'h0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        #1;
        chk1("b2b_add_valid", out_valid, 1'b1);
        chk("b2b_add_rd", 32'(out_rd_addr), 32'd3);
        chk("b2b_add_ctrl", 32'(out_alu_ctrl), 32'h0);
        tick();
        in_valid = 1'b0;
        set_fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        #1;
        chk("b2b_sub_src1", alu_src1, 32'h10);
        chk("b2b_sub_ctrl", 32'(out_alu_ctrl), 32'h8);
        chk1("b2b_sub_sel", out_add_sub_sel, 1'b1);
        chk("b2b_sub_rd", 32'(out_rd_addr), 32'd4);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Load x5 followed by a dependent instruction.
        set_in(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, 32'h40, 32'h0, 32'h8, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h304, 5'd5, 5'd2, 5'd6, 32'h0, 32'h2, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk1("lu_stall", load_use_stall, 1'b1);
        chk1("lu_in_ready", in_ready, 1'b0);
        chk1("lu_load_mem_read", out_mem_read, 1'b1);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h5A5A);
        #1;
        chk1("lu_bubble_valid", out_valid, 1'b0);
        chk1("lu_bubble_reg_write", out_reg_write, 1'b0);
        chk1("lu_bubble_mem_read", out_mem_read, 1'b0);
        chk1("lu_stall_cleared", load_use_stall, 1'b0);
        chk1("lu_ready_again", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk1("lu_dep_valid", out_valid, 1'b1);
        chk("lu_dep_rd", 32'(out_rd_addr), 32'd6);
        chk("lu_dep_src1", alu_src1, 32'h5A5A);
        tick();

        // Hold for 3 cycles; forwarded value seen only on the first.
        set_in(1'b1, 32'h400, 5'd1, 5'd7, 5'd8, 32'h1, 32'h1111, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) set_fwd(1'b1, 5'd7, 32'hABCD, 1'b0, 5'd0, 32'h0);
            else        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            #1;
            chk1("hold_valid", out_valid, 1'b1);
            chk1("hold_in_ready", in_ready, 1'b0);
            chk("hold_src2", alu_src2, 32'hABCD);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_src2", alu_src2, 32'hABCD);
        chk("hold_release_store", out_store_data, 32'hABCD);
        tick();
        #1;
        chk1("hold_drained", out_valid, 1'b0);

        // Flush with a held instruction and an incoming one.
        set_in(1'b1, 32'h500, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h600, 5'd1, 5'd2, 5'd10, 32'h1, 32'h2, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        chk1("flush_held_valid", out_valid, 1'b1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_reg_write", out_reg_write, 1'b0);
        chk1("flush_mem_write", out_mem_write, 1'b0);
        chk("flush_not_captured_pc", out_pc, 32'h500);
        tick();

        // Asynchronous reset while an instruction is held.
        set_in(1'b1, 32'h40, 5'd3, 5'd4, 5'd11, 32'h3, 32'h4, 32'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        set_fwd(1'b1, 5'd3, 32'hCAFE, 1'b1, 5'd4, 32'hBEEF);
        #1;
        chk1("midrst_before_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_reg_write", out_reg_write, 1'b0);
        chk1("midrst_mem_write", out_mem_write, 1'b0);
        chk("midrst_pc", out_pc, 32'h0);
        chk("midrst_src1", alu_src1, 32'h0);
        chk("midrst_src2", alu_src2, 32'h0);
        chk("midrst_rd", 32'(out_rd_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_after_valid", out_valid, 1'b0);
        tick();

        // Randomized run against the held-slot model; DUT is empty here.
        m = '{v: 1'b0, pc: 32'h0, r1: 5'd0, r2: 5'd0, rd: 5'd0, d1: 32'h0, d2: 32'h0,
              imm: 32'h0, ui: 1'b0, ctrl: 4'h0, asel: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_pc          = $urandom;
            in_rs1_addr    = 5'($urandom_range(0, 7));
            in_rs2_addr    = 5'($urandom_range(0, 7));
            in_rd_addr     = 5'($urandom_range(0, 7));
            in_rs1_data    = $urandom;
            in_rs2_data    = $urandom;
            in_imm         = $urandom;
            in_use_imm     = 1'($urandom_range(0, 1));
            in_alu_ctrl    = 4'($urandom_range(0, 15));
            in_add_sub_sel = 1'($urandom_range(0, 1));
            in_reg_write   = 1'($urandom_range(0, 1));
            in_mem_read    = ($urandom_range(0, 2) == 0);
            in_mem_write   = 1'($urandom_range(0, 1));
            flush          = ($urandom_range(0, 15) == 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            mem_fwd_we     = 1'($urandom_range(0, 1));
            mem_fwd_rd     = 5'($urandom_range(0, 7));
            mem_fwd_data   = $urandom;
            wb_fwd_we      = 1'($urandom_range(0, 1));
            wb_fwd_rd      = 5'($urandom_range(0, 7));
            wb_fwd_data    = $urandom;
            #1;

            e_stall = m.v && m.mr && (m.rd != 5'd0) && in_valid &&
                      (in_rs1_addr == m.rd || in_rs2_addr == m.rd);
            e_rdy   = (!m.v || out_ready) && !e_stall;
            e_acc   = in_valid && e_rdy && !flush;

            chk1("rnd_in_ready", in_ready, e_rdy);
            chk1("rnd_stall", load_use_stall, e_stall);
            chk1("rnd_out_valid", out_valid, m.v);
            chk1("rnd_reg_write", out_reg_write, m.v && m.rw);
            chk1("rnd_mem_read", out_mem_read, m.v && m.mr);
            chk1("rnd_mem_write", out_mem_write, m.v && m.mw);
            if (m.v) begin
                chk("rnd_src1", alu_src1, model_fwd(m.r1, m.d1));
                chk("rnd_src2", alu_src2, m.ui ? m.imm : model_fwd(m.r2, m.d2));
                chk("rnd_store", out_store_data, model_fwd(m.r2, m.d2));
                chk("rnd_pc", out_pc, m.pc);
                chk("rnd_rd", 32'(out_rd_addr), 32'(m.rd));
                chk("rnd_ctrl", 32'(out_alu_ctrl), 32'(m.ctrl));
                chk1("rnd_sel", out_add_sub_sel, m.asel);
            end

            mn = m;
            if (e_acc) begin
                mn.v = 1'b1; mn.pc = in_pc;
                mn.r1 = in_rs1_addr; mn.r2 = in_rs2_addr; mn.rd = in_rd_addr;
                mn.d1 = (in_rs1_addr != 0 && wb_fwd_we && wb_fwd_rd == in_rs1_addr) ? wb_fwd_data : in_rs1_data;
                mn.d2 = (in_rs2_addr != 0 && wb_fwd_we && wb_fwd_rd == in_rs2_addr) ? wb_fwd_data : in_rs2_data;
                mn.imm = in_imm; mn.ui = in_use_imm; mn.ctrl = in_alu_ctrl;
                mn.asel = in_add_sub_sel; mn.rw = in_reg_write;
                mn.mr = in_mem_read; mn.mw = in_mem_write;
            end else if (flush) begin
                mn.v = 1'b0;
            end else if (m.v && out_ready) begin
                mn.v = 1'b0;
            end else if (m.v) begin
                mn.d1 = model_fwd(m.r1, m.d1);
                mn.d2 = model_fwd(m.r2, m.d2);
            end
            tick();
            m = mn;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the ALU in the Eka integer core.
- Captures one decoded instruction per handshake and presents the final ALU operands, applying EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts a bubble.
- Provides upstream/downstream valid/ready flow control and a synchronous flush for branch redirect.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode has an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_pc  in  XLEN  instruction PC
in_rs1_addr  in  RA_W  source 1 index
in_rs2_addr  in  RA_W  source 2 index
in_rd_addr  in  RA_W  destination index
in_rs1_data  in  XLEN  regfile read 1
in_rs2_data  in  XLEN  regfile read 2
in_imm  in  XLEN  sign-extended immediate
in_use_imm  in  1  1: ALU src2 = imm, 0: src2 = rs2
in_alu_ctrl  in  4  ALU opcode (0000 add, 1000 sub)
in_add_sub_sel  in  1  add/sub select, passed through
in_reg_write  in  1  instruction writes rd
in_mem_read  in  1  instruction is a load
in_mem_write  in  1  instruction is a store
flush  in  1  discard held and incoming instruction
mem_fwd_we  in  1  EX/MEM stage writes a register
mem_fwd_rd  in  RA_W  EX/MEM destination
mem_fwd_data  in  XLEN  EX/MEM result
wb_fwd_we  in  1  MEM/WB stage writes a register
wb_fwd_rd  in  RA_W  MEM/WB destination
wb_fwd_data  in  XLEN  MEM/WB result
out_valid  out  1  held instruction valid
out_ready  in  1  ALU/EX stage consumes this cycle
alu_src1  out  XLEN  forwarded rs1
alu_src2  out  XLEN  imm or forwarded rs2
out_store_data  out  XLEN  forwarded rs2 (always, for stores)
out_alu_ctrl  out  4  held ALU opcode
out_add_sub_sel  out  1  held add/sub select
out_rd_addr  out  RA_W  held rd
out_reg_write  out  1  held reg_write AND out_valid
out_mem_read  out  1  held mem_read AND out_valid
out_mem_write  out  1  held mem_write AND out_valid
out_pc  out  XLEN  held PC
load_use_stall  out  1  hazard stall indicator

Behaviour:
- Reset (rst_n low, asynchronous): valid=0; every held field=0; all outputs 0; in_ready=1 once released.
- Held state: valid bit plus one copy of every in_* field.
- Forwarding function fwd(addr, base): addr==0 → 0; else mem_fwd_we & mem_fwd_rd==addr → mem_fwd_data; else wb_fwd_we & wb_fwd_rd==addr → wb_fwd_data; else base. EX/MEM has priority over MEM/WB.
- Output operands are combinational on held state: alu_src1=fwd(rs1); out_store_data=fwd(rs2); alu_src2 = use_imm ? imm : fwd(rs2).
- load_use_stall = valid & held mem_read & held rd!=0 & in_valid & (in_rs1_addr==held rd | in_rs2_addr==held rd). Both sources are compared regardless of in_use_imm (conservative).
- in_ready = (~valid | out_ready) & ~load_use_stall.
- Capture on edge when in_valid & in_ready & ~flush:
  - valid<=1.
  - Fields latched; operand data latched as the WB-only bypass of in_rsX_data. This covers a regfile write in the same cycle.
  - Latency is 1 cycle from accept to out_valid.
- Drain without capture (valid & out_ready & no accept): valid<=0. This includes a load-use cycle, so the bubble enters the stage.
- Hold (valid & ~out_ready): fields are stable, but latched rs1/rs2 data is overwritten with fwd() each cycle. Forwarded values thus survive after the producer retires.
- flush: valid<=0 next edge, overriding capture and hold. The incoming instruction that cycle is dropped even if in_ready=1.
- out_valid=valid. Control outputs are gated by valid, so a bubble never writes registers or memory.
- Address 0 is never forwarded and never triggers load-use.

Test Plan:
- Reset mid-operation: valid instruction held, rst_n pulsed low between edges → out_valid=0 immediately, all outputs 0, in_ready=1 after release.
- Back-to-back ADD x3=x1+x2 then SUB x4=x3-x1, mem_fwd rd=3 data=0x10 → second instruction alu_src1=0x10; mem wins over wb_fwd rd=3 data=0x20.
- Load x5 held, next in_rs1=5 → load_use_stall=1, in_ready=0 one cycle; bubble emitted (out_valid=0); dependent instruction accepted next cycle.
- out_ready=0 for 3 cycles with mem_fwd rd=7 data=0xABCD present only in the first cycle → alu_src2 (rs2=7, use_imm=0) stays 0xABCD through release.
- flush asserted with in_valid=1 and valid=1 → next cycle out_valid=0, out_reg_write=0, nothing captured.
- rs1=0 with mem_fwd rd=0 data=0xFFFF → alu_src1=0; in_use_imm=1, imm=0xFFFFFFFC → alu_src2=0xFFFFFFFC, out_store_data=fwd(rs2).
